// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer scheduler.
//   - Source indices and count (alarm, chime, key).
//   - FSM state encoding.
//   - Default width of the beep-count fields.
//   - prio_onehot(): the lowest set bit of a request vector as a one-hot value.
//     Index 0 (alarm) has the highest priority.
package buzz_pkg;

  localparam int NUM_SRC   = 3;
  localparam int SRC_ALARM = 0;
  localparam int SRC_CHIME = 1;
  localparam int SRC_KEY   = 2;

  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [NUM_SRC-1:0] prio_onehot(input logic [NUM_SRC-1:0] p);
    return p & (~p + NUM_SRC'(1));
  endfunction

endpackage

// File: rtl/buzz_tick_div.sv
// Beep tick divider.
// It counts 0..TICK_DIV-1 and pulses tick while the count sits on the terminal value.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (count to 0)
//   clr   force the count to 0. The scheduler asserts this on every grant, so the
//         first beep phase starts on a clean tick boundary.
//   tick  one-cycle pulse every TICK_DIV cycles
module buzz_tick_div #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int         DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam [DIV_W-1:0] LAST  = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A clear restarts the phase, so a coincident terminal count must not be seen as a tick.
  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/buzz_scheduler.sv
// Buzzer scheduler.
// Arbitrates between alarm (bit 0), chime (bit 1) and key click (bit 2).
// The served request is played as N timed on/off beeps on buzz_en.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req           one-cycle request pulses, one per source
//   req_count     beep count per source (slice i = [i*CNT_W +: CNT_W]), sampled with req[i]
//   cancel        abort the current sequence and drop every pending request
//   buzz_en       tone generator enable
//   busy          high whenever the FSM is not idle
//   grant         one-hot source being served (0 when idle)
//   ack/done/abort  one-cycle pulses: granted / finished normally / preempted or cancelled
//   beeps_left    remaining beeps of the current sequence, including the one sounding
// All outputs are registered.
module buzz_scheduler
  import buzz_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*CNT_W-1:0] req_count,
  input  logic                     cancel,
  output logic                     buzz_en,
  output logic                     busy,
  output logic [NUM_SRC-1:0]       grant,
  output logic [NUM_SRC-1:0]       ack,
  output logic [NUM_SRC-1:0]       done,
  output logic [NUM_SRC-1:0]       abort,
  output logic [CNT_W-1:0]         beeps_left
);

  logic [NUM_SRC-1:0] pend_all;
  logic [CNT_W-1:0]   cnt_all [NUM_SRC];
  logic [NUM_SRC-1:0] take;      // pending flags consumed by a grant this cycle
  logic               div_clr;
  logic               tick;

  // Per-source request capture and pending latch.
  // Requests pass through one input register before reaching the pending flag.
  // As a result, a request sampled at edge t is acknowledged at edge t+2.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic             req_q, req_d, pend_q, pend_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d, cnt_q, cnt_d;

    always_comb begin
      req_d  = req[gi] & ~cancel;  // a request alongside cancel is discarded
      rcnt_d = req_count[gi*CNT_W +: CNT_W];
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (take[gi]) pend_d = 1'b0;
      // A fresh request wins over a same-cycle grant: it becomes the next pending sequence.
      if (req_q && rcnt_q != '0) begin
        pend_d = 1'b1;
        cnt_d  = rcnt_q;
      end
      if (cancel) pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        req_q  <= 1'b0;
        rcnt_q <= '0;
        pend_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        req_q  <= req_d;
        rcnt_q <= rcnt_d;
        pend_q <= pend_d;
        cnt_q  <= cnt_d;
      end
    end

    assign pend_all[gi] = pend_q;
    assign cnt_all[gi]  = cnt_q;
  end

  buzz_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  state_e             state_q, state_d;
  logic               buzz_en_q, buzz_en_d, busy_q, busy_d;
  logic [NUM_SRC-1:0] grant_q, grant_d, ack_q, ack_d, done_q, done_d, abort_q, abort_d;
  logic [CNT_W-1:0]   beeps_left_q, beeps_left_d;
  logic [15:0]        ph_q, ph_d;     // ticks elapsed in the current ON/OFF phase
  logic [15:0]        ph_last;
  logic [NUM_SRC-1:0] sel;
  logic [CNT_W-1:0]   sel_cnt;
  logic               do_start;

  always_comb begin
    state_d      = state_q;
    buzz_en_d    = buzz_en_q;
    grant_d      = grant_q;
    ack_d        = '0;
    done_d       = '0;
    abort_d      = '0;
    beeps_left_d = beeps_left_q;
    ph_d         = ph_q;
    take         = '0;
    div_clr      = 1'b0;
    do_start     = 1'b0;
    sel          = prio_onehot(pend_all);
    sel_cnt      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel[i]) sel_cnt = cnt_all[i];
    end
    ph_last = (state_q == ON) ? 16'(ON_TICKS - 1) : 16'(OFF_TICKS - 1);

    if (cancel) begin
      state_d      = IDLE;
      buzz_en_d    = 1'b0;
      grant_d      = '0;
      beeps_left_d = '0;
      ph_d         = '0;
      abort_d      = grant_q;
    end else begin
      unique case (state_q)
        IDLE: do_start = |pend_all;
        ON, OFF: begin
          // Only a pending alarm may preempt, and only a lower source.
          // When pend_all[0] is set, sel is already the alarm.
          if (pend_all[SRC_ALARM] && !grant_q[SRC_ALARM]) begin
            abort_d  = grant_q;
            do_start = 1'b1;
          end else if (tick) begin
            if (ph_q == ph_last) begin
              ph_d = '0;
              if (state_q == OFF) begin
                state_d   = ON;
                buzz_en_d = 1'b1;
              end else if (beeps_left_q == CNT_W'(1)) begin
                state_d      = IDLE;
                buzz_en_d    = 1'b0;
                done_d       = grant_q;
                grant_d      = '0;
                beeps_left_d = '0;
              end else begin
                state_d      = OFF;
                buzz_en_d    = 1'b0;
                beeps_left_d = beeps_left_q - CNT_W'(1);
              end
            end else begin
              ph_d = ph_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (do_start) begin
        take         = sel;
        grant_d      = sel;
        ack_d        = sel;
        beeps_left_d = sel_cnt;
        buzz_en_d    = 1'b1;
        state_d      = ON;
        ph_d         = '0;
        div_clr      = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      buzz_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      abort_q      <= '0;
      beeps_left_q <= '0;
      ph_q         <= '0;
    end else begin
      state_q      <= state_d;
      buzz_en_q    <= buzz_en_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      beeps_left_q <= beeps_left_d;
      ph_q         <= ph_d;
    end
  end

  assign buzz_en    = buzz_en_q;
  assign busy       = busy_q;
  assign grant      = grant_q;
  assign ack        = ack_q;
  assign done       = done_q;
  assign abort      = abort_q;
  assign beeps_left = beeps_left_q;

endmodule

// File: tb/tb_buzz_scheduler.sv
// Directed bench for buzz_scheduler with TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1.
// With these settings each beep is 8 cycles high, and the gap between beeps is 4 cycles low.
// Inputs change on the falling edge, and outputs are checked on the falling edge.
module tb_buzz_scheduler;

  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic [2:0]       req;
  logic [3*CNT_W-1:0] req_count;
  logic             cancel;
  logic             buzz_en;
  logic             busy;
  logic [2:0]       grant;
  logic [2:0]       ack;
  logic [2:0]       done;
  logic [2:0]       abort;
  logic [CNT_W-1:0] beeps_left;

  int checks = 0;
  int errors = 0;

  buzz_scheduler #(
    .TICK_DIV  (4),
    .ON_TICKS  (2),
    .OFF_TICKS (1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_count  (req_count),
    .cancel     (cancel),
    .buzz_en    (buzz_en),
    .busy       (busy),
    .grant      (grant),
    .ack        (ack),
    .done       (done),
    .abort      (abort),
    .beeps_left (beeps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tk();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_buzz"},  32'(buzz_en),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_grant"}, 32'(grant),      32'd0);
    check({tag, "_ack"},   32'(ack),        32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_abort"}, 32'(abort),      32'd0);
    check({tag, "_beeps"}, 32'(beeps_left), 32'd0);
  endtask

  function automatic logic [3*CNT_W-1:0] mk(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] c,
                                             input logic [CNT_W-1:0] k);
    return {k, c, a};
  endfunction

  initial begin
    logic exp_b;
    rst = 1'b1; req = '0; req_count = '0; cancel = 1'b0;
    repeat (3) tk();
    check_all_zero("reset");
    rst = 1'b0;
    tk();
    check_all_zero("post_reset");
    $display("txn reset done");

    // T1: chime, 3 beeps. Ack arrives two edges after the sampling edge.
    req = 3'b010; req_count = mk(0, 3, 0);
    tk(); req = '0; req_count = '0;
    check("t1_ack_early1", 32'(ack), 32'd0);
    tk();
    check("t1_ack_early2", 32'(ack), 32'd0);
    tk();
    check("t1_ack",   32'(ack),        32'b010);
    check("t1_grant", 32'(grant),      32'b010);
    check("t1_beeps", 32'(beeps_left), 32'd3);
    check("t1_busy",  32'(busy),       32'd1);
    for (int k = 0; k <= 32; k++) begin
      exp_b = (k < 8) || (k >= 12 && k < 20) || (k >= 24 && k < 32);
      check("t1_buzz", 32'(buzz_en), 32'(exp_b));
      check("t1_done", 32'(done), (k == 32) ? 32'b010 : 32'd0);
      if (k == 20) check("t1_beeps_mid", 32'(beeps_left), 32'd1);
      if (k == 32) begin
        check("t1_busy_end",  32'(busy),       32'd0);
        check("t1_grant_end", 32'(grant),      32'd0);
        check("t1_beeps_end", 32'(beeps_left), 32'd0);
      end
      if (k < 32) tk();
    end
    tk();
    $display("txn chime x3 complete");

    // T2: a key request with count 0 is ignored.
    req = 3'b100; req_count = mk(0, 0, 0);
    tk(); req = '0;
    for (int k = 0; k < 5; k++) begin
      check("t2_ack",  32'(ack),     32'd0);
      check("t2_buzz", 32'(buzz_en), 32'd0);
      check("t2_busy", 32'(busy),    32'd0);
      tk();
    end
    $display("txn key count0 ignored");

    // T3: key(2) and chime(1) requested together. Chime is served first.
    // Key follows after one idle cycle.
    req = 3'b110; req_count = mk(0, 1, 2);
    tk(); req = '0; req_count = '0;
    tk(); tk();
    check("t3_ack_chime", 32'(ack),   32'b010);
    check("t3_grant",     32'(grant), 32'b010);
    repeat (8) tk();
    check("t3_done_chime", 32'(done),    32'b010);
    check("t3_idle_buzz",  32'(buzz_en), 32'd0);
    check("t3_idle_busy",  32'(busy),    32'd0);
    check("t3_idle_ack",   32'(ack),     32'd0);
    tk();
    check("t3_ack_key",   32'(ack),        32'b100);
    check("t3_grant_key", 32'(grant),      32'b100);
    check("t3_buzz_key",  32'(buzz_en),    32'd1);
    check("t3_beeps_key", 32'(beeps_left), 32'd2);
    repeat (20) tk();
    check("t3_done_key", 32'(done), 32'b100);
    check("t3_busy_end", 32'(busy), 32'd0);
    tk();
    $display("txn chime+key priority");

    // T4: chime(5) is preempted by alarm(2) during the OFF gap after beep 2.
    req = 3'b010; req_count = mk(0, 5, 0);
    tk(); req = '0; req_count = '0;
    tk(); tk();
    check("t4_ack_chime", 32'(ack), 32'b010);
    repeat (20) tk();
    check("t4_off_buzz",  32'(buzz_en),    32'd0);
    check("t4_off_beeps", 32'(beeps_left), 32'd3);
    req = 3'b001; req_count = mk(2, 0, 0);
    tk(); req = '0; req_count = '0;
    check("t4_abort_early1", 32'(abort), 32'd0);
    tk();
    check("t4_abort_early2", 32'(abort), 32'd0);
    tk();
    check("t4_abort",  32'(abort),      32'b010);
    check("t4_ack",    32'(ack),        32'b001);
    check("t4_grant",  32'(grant),      32'b001);
    check("t4_buzz",   32'(buzz_en),    32'd1);
    check("t4_beeps",  32'(beeps_left), 32'd2);
    for (int k = 1; k <= 20; k++) begin
      tk();
      exp_b = (k < 8) || (k >= 12 && k < 20);
      check("t4_alarm_buzz", 32'(buzz_en), 32'(exp_b));
      check("t4_alarm_done", 32'(done), (k == 20) ? 32'b001 : 32'd0);
      check("t4_no_abort",   32'(abort), 32'd0);
    end
    for (int k = 0; k < 6; k++) begin
      tk();
      check("t4_no_resume_ack",  32'(ack),  32'd0);
      check("t4_no_resume_busy", 32'(busy), 32'd0);
    end
    $display("txn alarm preempts chime");

    // T5: cancel during alarm ON while a key request is pending.
    req = 3'b001; req_count = mk(3, 0, 0);
    tk(); req = '0; req_count = '0;
    tk(); tk();
    check("t5_ack_alarm", 32'(ack), 32'b001);
    tk();
    req = 3'b100; req_count = mk(0, 0, 2);
    tk(); req = '0; req_count = '0;
    tk(); tk();
    check("t5_buzz_on", 32'(buzz_en), 32'd1);
    cancel = 1'b1;
    tk(); cancel = 1'b0;
    check("t5_buzz",  32'(buzz_en),    32'd0);
    check("t5_abort", 32'(abort),      32'b001);
    check("t5_busy",  32'(busy),       32'd0);
    check("t5_grant", 32'(grant),      32'd0);
    check("t5_beeps", 32'(beeps_left), 32'd0);
    for (int k = 0; k < 30; k++) begin
      tk();
      check("t5_key_never", 32'(ack),     32'd0);
      check("t5_quiet",     32'(buzz_en), 32'd0);
    end
    $display("txn cancel drops pending");

    // T6: reset mid-beep, then a normal one-beep chime.
    req = 3'b010; req_count = mk(0, 3, 0);
    tk(); req = '0; req_count = '0;
    tk(); tk();
    check("t6_ack", 32'(ack), 32'b010);
    tk(); tk();
    check("t6_buzz_pre", 32'(buzz_en), 32'd1);
    rst = 1'b1;
    tk();
    check_all_zero("t6_rst");
    rst = 1'b0;
    req = 3'b010; req_count = mk(0, 1, 0);
    tk(); req = '0; req_count = '0;
    tk(); tk();
    check("t6_ack2", 32'(ack), 32'b010);
    for (int k = 0; k <= 8; k++) begin
      check("t6_buzz", 32'(buzz_en), 32'(k < 8));
      check("t6_done", 32'(done), (k == 8) ? 32'b010 : 32'd0);
      if (k < 8) tk();
    end
    $display("txn reset mid-beep recovery");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
